// File: rtl/program_counter.sv
// Program counter: two-byte vector fetch after reset/restart, then load/increment in RUN.
// Optional page-cross flag register is built only when PC_PAGE_CROSS_EN is defined.
module program_counter #(
    parameter int                    DATA_W       = 8,
    parameter logic [2*DATA_W-1:0]   RESET_VECTOR = 16'hFFFC
) (
    input  logic                  ph0,
    input  logic                  reset_n,
    input  logic                  restart,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W-1:0]     adl_in,
    input  logic [DATA_W-1:0]     adh_in,
    input  logic                  load_lo,
    input  logic                  load_hi,
    input  logic                  inc,
    output logic [2*DATA_W-1:0]   addr,
    output logic [2*DATA_W-1:0]   pc,
    output logic                  busy,
    output logic                  page_cross,
    output logic [1:0]            dbg_state
);
    localparam int ADDR_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;

`ifdef PC_PAGE_CROSS_EN
    logic                pcx_q, pcx_d;
`endif

    always_ff @(posedge ph0 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= VEC_LO;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_PAGE_CROSS_EN
    always_ff @(posedge ph0 or negedge reset_n) begin
        if (!reset_n) begin
            pcx_q <= 1'b0;
        end else begin
            pcx_q <= pcx_d;
        end
    end
    assign page_cross = pcx_q;
`else
    assign page_cross = 1'b0;
`endif

    // restart wins over everything and leaves PC untouched until VEC_LO captures.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_PAGE_CROSS_EN
        pcx_d   = 1'b0;
`endif
        if (restart) begin
            state_d = VEC_LO;
        end else begin
            case (state_q)
                VEC_LO: begin
                    pc_d[DATA_W-1:0] = data_in;
                    state_d          = VEC_HI;
                end
                VEC_HI: begin
                    pc_d[ADDR_W-1:DATA_W] = data_in;
                    state_d               = RUN;
                end
                RUN: begin
                    if (load_lo || load_hi) begin
                        if (load_lo) pc_d[DATA_W-1:0]      = adl_in;
                        if (load_hi) pc_d[ADDR_W-1:DATA_W] = adh_in;
                    end else if (inc) begin
                        pc_d = pc_q + ADDR_W'(1);
`ifdef PC_PAGE_CROSS_EN
                        pcx_d = &pc_q[DATA_W-1:0];
`endif
                    end
                end
                default: state_d = VEC_LO;
            endcase
        end
    end

    always_comb begin
        addr = pc_q;
        busy = 1'b1;
        case (state_q)
            VEC_LO:  addr = RESET_VECTOR;
            VEC_HI:  addr = RESET_VECTOR + ADDR_W'(1);
            RUN:     busy = 1'b0;
            default: addr = RESET_VECTOR;
        endcase
    end

    assign pc        = pc_q;
    assign dbg_state = state_q;

endmodule
